exception_ctrl: RTL and testbench
=================================

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_HWINT, default 6, meaning the count of hardware interrupt lines mapped to Cause.IP[7:2] upward (range 1..6).
REQ-002 The block SHALL have parameter FWD_DEPTH, default 2, meaning the count of CP0 write-forwarding sources; index 0 is youngest.
REQ-003 The block SHALL have parameter EXC_VECTOR, default 32'hBFC00380, meaning the redirect target for all non-ERET exceptions.
REQ-004 The block SHALL have ports: clk input 1 system clock; rst input 1 asynchronous active-high reset.
REQ-005 The block SHALL have ports: hw_int_i input NUM_HWINT, level interrupt lines; mem_valid_i input 1, MEM-stage instruction valid; mem_pc_i input 32, MEM-stage PC; mem_bd_i input 1, delay-slot flag; mem_exc_i input exc_vec_t, collected exception flags.
REQ-006 The block SHALL have ports: cp0_status_i, cp0_cause_i, cp0_epc_i input 32 each, architectural CP0 values.
REQ-007 The block SHALL have ports: fwd_wr_i input FWD_DEPTH; fwd_addr_i input FWD_DEPTH x 5; fwd_data_i input FWD_DEPTH x 32, pending CP0 writes.
REQ-008 The block SHALL have ports: kill_o output 1, suppresses MEM register/HILO writes; flush_o output 1, flushes IF/ID/EXE/MEM/WB registers; redirect_valid_o output 1; redirect_pc_o output 32; redirect_ready_i input 1, fetch accepts redirect.
REQ-009 The block SHALL have ports: commit_o output 1, CP0 exception-entry write strobe; commit_code_o output 5, ExcCode; commit_epc_o output 32; commit_bd_o output 1; eret_o output 1, clear-EXL strobe; busy_o output 1, FSM not IDLE.

Function
REQ-010 Effective Status/EPC SHALL be the data of the lowest-index fwd entry with fwd_wr_i set and matching address (12/14), else the cp0 input.
REQ-011 Effective Cause SHALL take bits 9:8 from the lowest-index matching forward (address 13), all other bits from cp0_cause_i, with IP[2+NUM_HWINT-1:2] replaced by the sampled hw_int_i.
REQ-012 Interrupt SHALL be pending when (Cause[15:8] & Status[15:8]) != 0, Status.EXL == 0 and Status.IE == 1.
REQ-013 Priority SHALL be, with ExcCode: Int 0 > fetch AdEL 4 > RI 10 > Sys 8 > Bp 9 > Ov 12 > AdES 5 > data AdEL 4 > ERET (no code).
REQ-014 Resolution SHALL occur only in IDLE with mem_valid_i == 1; kill_o SHALL assert combinationally in that same cycle when any event resolves.
REQ-015 FSM states SHALL be IDLE, FLUSH, REDIRECT; IDLE->FLUSH on resolved event; FLUSH->REDIRECT unconditionally after one cycle; REDIRECT->IDLE on the cycle redirect_ready_i == 1.
REQ-016 In FLUSH, flush_o SHALL be 1 for exactly one cycle, and commit_o (non-ERET) or eret_o (ERET) SHALL pulse for exactly one cycle.
REQ-017 commit_epc_o SHALL be mem_pc_i - 4 when mem_bd_i == 1, else mem_pc_i, latched at resolution; commit_bd_o SHALL equal the latched mem_bd_i.
REQ-018 In REDIRECT, redirect_valid_o SHALL be 1 and redirect_pc_o stable: EXC_VECTOR, or the effective EPC latched at resolution for ERET.
REQ-019 While busy_o == 1, mem_valid_i and mem_exc_i SHALL be ignored; an interrupt arriving during REDIRECT SHALL be taken on the next valid MEM instruction.

Reset
REQ-020 On rst == 1, asynchronously, the FSM SHALL go to IDLE, all outputs SHALL be 0, redirect_pc_o SHALL be 0, and synchronizer flops SHALL clear; reset mid-REDIRECT SHALL abandon the redirect.

Configuration
REQ-021 With EXC_INT_SYNC_EN defined, hw_int_i SHALL pass through a 2-flop synchronizer (2-cycle latency to Cause.IP); without it, hw_int_i SHALL feed IP combinationally.

Structure
REQ-022 exc_vec_t, ExcCode constants, CP0 register addresses and FSM state enum SHALL live in the shared CPU package.
REQ-023 Forwarding SHALL be a sub-module cp0_fwd_mux, instantiated three times (Status, Cause, EPC).

Verification
REQ-024 Ov with mem_pc_i=0x80001000, bd=0 -> kill_o same cycle; flush_o 1 cycle; commit_code_o=12, commit_epc_o=0x80001000; redirect_pc_o=0xBFC00380.
REQ-025 Sys in delay slot, pc=0x80002004 -> commit_epc_o=0x80002000, commit_bd_o=1.
REQ-026 ERET with cp0_epc_i=0x1000, fwd[0] writing EPC=0x2000 -> eret_o pulse, redirect_pc_o=0x2000, no commit_o.
REQ-027 Status=0x0000FF01, hw_int_i[0]=1 with RI flagged -> commit_code_o=0 (interrupt wins); with EXC_INT_SYNC_EN, raised interrupt taken 2 cycles later.
REQ-028 redirect_ready_i held 0 for 5 cycles -> redirect_valid_o and redirect_pc_o stable, busy_o=1; new Ov during wait ignored.
REQ-029 rst asserted mid-REDIRECT -> all outputs 0 immediately, FSM in IDLE.

Source files
------------

// File: rtl/exception_ctrl_pkg.sv
// Shared CPU definitions for the exception controller: exception flag
// vector, ExcCode values, CP0 register addresses and FSM state encoding.
package exception_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CODE_W = 5;

    // ExcCode values written to Cause.ExcCode on exception entry
    localparam logic [CODE_W-1:0] EXC_INT  = 5'd0;
    localparam logic [CODE_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [CODE_W-1:0] EXC_ADES = 5'd5;
    localparam logic [CODE_W-1:0] EXC_SYS  = 5'd8;
    localparam logic [CODE_W-1:0] EXC_BP   = 5'd9;
    localparam logic [CODE_W-1:0] EXC_RI   = 5'd10;
    localparam logic [CODE_W-1:0] EXC_OV   = 5'd12;

    // CP0 register numbers
    localparam logic [REG_AW-1:0] CP0_STATUS = 5'd12;
    localparam logic [REG_AW-1:0] CP0_CAUSE  = 5'd13;
    localparam logic [REG_AW-1:0] CP0_EPC    = 5'd14;

    // Status bit positions
    localparam int unsigned STATUS_IE  = 0;
    localparam int unsigned STATUS_EXL = 1;

    // Exception flags collected down the pipe for the MEM-stage instruction
    typedef struct packed {
        logic adel_if;   // fetch address error
        logic ri;        // reserved instruction
        logic sys;       // syscall
        logic bp;        // break
        logic ov;        // arithmetic overflow
        logic ades;      // store address error
        logic adel_dat;  // load address error
        logic eret;      // exception return
    } exc_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } exc_state_e;

endpackage

// File: rtl/exception_ctrl_fwd_mux.sv
// cp0_fwd_mux: picks the youngest pending CP0 write to one register,
// falling back to the architectural value when nothing matches.
module cp0_fwd_mux
    import exception_ctrl_pkg::*;
#(
    parameter int unsigned       FWD_DEPTH = 2,
    parameter logic [REG_AW-1:0] ADDR      = CP0_STATUS
) (
    input  logic [FWD_DEPTH-1:0]             fwd_wr_i,
    input  logic [FWD_DEPTH-1:0][REG_AW-1:0] fwd_addr_i,
    input  logic [FWD_DEPTH-1:0][XLEN-1:0]   fwd_data_i,
    input  logic [XLEN-1:0]                  arch_i,
    output logic [XLEN-1:0]                  eff_c_o
);

    // Scan oldest to youngest so index 0 (youngest) has the final say
    always_comb begin
        eff_c_o = arch_i;
        for (int i = int'(FWD_DEPTH) - 1; i >= 0; i--) begin
            if (fwd_wr_i[i] && (fwd_addr_i[i] == ADDR)) begin
                eff_c_o = fwd_data_i[i];
            end
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl: resolves MEM-stage exceptions/interrupts/ERET, kills the
// instruction, flushes the pipe, commits CP0 entry state and redirects fetch.
// Optional macro EXC_INT_SYNC_EN adds a 2-flop synchronizer on hw_int_i.
module exception_ctrl
    import exception_ctrl_pkg::*;
#(
    parameter int unsigned     NUM_HWINT  = 6,
    parameter int unsigned     FWD_DEPTH  = 2,
    parameter logic [XLEN-1:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_HWINT-1:0]             hw_int_i,
    input  logic                             mem_valid_i,
    input  logic [XLEN-1:0]                  mem_pc_i,
    input  logic                             mem_bd_i,
    input  exc_vec_t                         mem_exc_i,
    input  logic [XLEN-1:0]                  cp0_status_i,
    input  logic [XLEN-1:0]                  cp0_cause_i,
    input  logic [XLEN-1:0]                  cp0_epc_i,
    input  logic [FWD_DEPTH-1:0]             fwd_wr_i,
    input  logic [FWD_DEPTH-1:0][REG_AW-1:0] fwd_addr_i,
    input  logic [FWD_DEPTH-1:0][XLEN-1:0]   fwd_data_i,
    output logic                             kill_o,
    output logic                             flush_o,
    output logic                             redirect_valid_o,
    output logic [XLEN-1:0]                  redirect_pc_o,
    input  logic                             redirect_ready_i,
    output logic                             commit_o,
    output logic [CODE_W-1:0]                commit_code_o,
    output logic [XLEN-1:0]                  commit_epc_o,
    output logic                             commit_bd_o,
    output logic                             eret_o,
    output logic                             busy_o
);

    exc_state_e          state_q, state_d;
    logic [XLEN-1:0]     status_c, cause_fwd_c, epc_c;
    logic [NUM_HWINT-1:0] hw_int_c;
    logic [7:0]          ip_c;
    logic                int_pend_c, evt_c, is_eret_c, resolve_c;
    logic [CODE_W-1:0]   code_c;
    logic                flush_d, commit_d, eret_d, rv_d, busy_d, bd_d;
    logic                flush_q, commit_q, eret_q, rv_q, busy_q, bd_q;
    logic [CODE_W-1:0]   code_d, code_q;
    logic [XLEN-1:0]     epc_d, epc_q, rpc_d, rpc_q;
    logic                unused_c;

    cp0_fwd_mux #(.FWD_DEPTH(FWD_DEPTH), .ADDR(CP0_STATUS)) u_fwd_status (
        .fwd_wr_i(fwd_wr_i), .fwd_addr_i(fwd_addr_i), .fwd_data_i(fwd_data_i),
        .arch_i(cp0_status_i), .eff_c_o(status_c)
    );
    cp0_fwd_mux #(.FWD_DEPTH(FWD_DEPTH), .ADDR(CP0_CAUSE)) u_fwd_cause (
        .fwd_wr_i(fwd_wr_i), .fwd_addr_i(fwd_addr_i), .fwd_data_i(fwd_data_i),
        .arch_i(cp0_cause_i), .eff_c_o(cause_fwd_c)
    );
    cp0_fwd_mux #(.FWD_DEPTH(FWD_DEPTH), .ADDR(CP0_EPC)) u_fwd_epc (
        .fwd_wr_i(fwd_wr_i), .fwd_addr_i(fwd_addr_i), .fwd_data_i(fwd_data_i),
        .arch_i(cp0_epc_i), .eff_c_o(epc_c)
    );

`ifdef EXC_INT_SYNC_EN
    logic [NUM_HWINT-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer for asynchronous interrupt lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= hw_int_i;
            sync2_q <= sync1_q;
        end
    end
    assign hw_int_c = sync2_q;
`else
    assign hw_int_c = hw_int_i;
`endif

    // Effective Cause.IP: software bits may be forwarded, hardware bits come from the pins
    always_comb begin
        ip_c = {cp0_cause_i[15:10], cause_fwd_c[9:8]};
        ip_c[2 +: NUM_HWINT] = hw_int_c;
    end

    assign int_pend_c = ((ip_c & status_c[15:8]) != 8'd0) &&
                        !status_c[STATUS_EXL] && status_c[STATUS_IE];

    // Fixed priority event selection
    always_comb begin
        evt_c     = 1'b1;
        is_eret_c = 1'b0;
        code_c    = EXC_INT;
        if (int_pend_c)                code_c = EXC_INT;
        else if (mem_exc_i.adel_if)    code_c = EXC_ADEL;
        else if (mem_exc_i.ri)         code_c = EXC_RI;
        else if (mem_exc_i.sys)        code_c = EXC_SYS;
        else if (mem_exc_i.bp)         code_c = EXC_BP;
        else if (mem_exc_i.ov)         code_c = EXC_OV;
        else if (mem_exc_i.ades)       code_c = EXC_ADES;
        else if (mem_exc_i.adel_dat)   code_c = EXC_ADEL;
        else if (mem_exc_i.eret)       is_eret_c = 1'b1;
        else                           evt_c = 1'b0;
    end

    assign resolve_c = (state_q == ST_IDLE) && mem_valid_i && evt_c && !rst;
    assign kill_o    = resolve_c;

    // Next state and next values of the registered outputs
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        epc_d    = epc_q;
        bd_d     = bd_q;
        rpc_d    = rpc_q;
        unique case (state_q)
            ST_IDLE:     if (resolve_c) state_d = ST_FLUSH;
            ST_FLUSH:    state_d = ST_REDIRECT;
            ST_REDIRECT: if (redirect_ready_i) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        flush_d  = resolve_c;
        commit_d = resolve_c && !is_eret_c;
        eret_d   = resolve_c && is_eret_c;
        rv_d     = (state_d == ST_REDIRECT);
        busy_d   = (state_d != ST_IDLE);
        if (resolve_c) begin
            code_d = code_c;
            epc_d  = mem_bd_i ? (mem_pc_i - XLEN'(4)) : mem_pc_i;
            bd_d   = mem_bd_i;
            rpc_d  = is_eret_c ? epc_c : EXC_VECTOR;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            flush_q  <= 1'b0;
            commit_q <= 1'b0;
            eret_q   <= 1'b0;
            rv_q     <= 1'b0;
            busy_q   <= 1'b0;
            code_q   <= '0;
            epc_q    <= '0;
            bd_q     <= 1'b0;
            rpc_q    <= '0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            commit_q <= commit_d;
            eret_q   <= eret_d;
            rv_q     <= rv_d;
            busy_q   <= busy_d;
            code_q   <= code_d;
            epc_q    <= epc_d;
            bd_q     <= bd_d;
            rpc_q    <= rpc_d;
        end
    end

    assign flush_o          = flush_q;
    assign commit_o         = commit_q;
    assign eret_o           = eret_q;
    assign redirect_valid_o = rv_q;
    assign busy_o           = busy_q;
    assign commit_code_o    = code_q;
    assign commit_epc_o     = epc_q;
    assign commit_bd_o      = bd_q;
    assign redirect_pc_o    = rpc_q;

    assign unused_c = ^{status_c[31:16], status_c[7:2], cp0_cause_i[31:16], cp0_cause_i[9:0],
                        cause_fwd_c[31:10], cause_fwd_c[7:0]};

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed scenarios plus randomized
// transactions checked against a rule-level reference model.
`timescale 1ns/1ps
module tb_exception_ctrl;
    import exception_ctrl_pkg::*;

    localparam int unsigned NUM_HWINT = 6;
    localparam int unsigned FWD_DEPTH = 2;
    localparam logic [31:0] VEC       = 32'hBFC00380;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NUM_HWINT-1:0]        hw_int;
    logic                        mem_valid;
    logic [31:0]                 mem_pc;
    logic                        mem_bd;
    exc_vec_t                    mem_exc;
    logic [31:0]                 cp0_status, cp0_cause, cp0_epc;
    logic [FWD_DEPTH-1:0]        fwd_wr;
    logic [FWD_DEPTH-1:0][4:0]   fwd_addr;
    logic [FWD_DEPTH-1:0][31:0]  fwd_data;
    logic                        kill, flush, rv, rdy, commit, bd, eret, busy;
    logic [31:0]                 rpc, cepc;
    logic [4:0]                  ccode;

    int n_cmp  = 0;
    int n_fail = 0;

    exception_ctrl #(.NUM_HWINT(NUM_HWINT), .FWD_DEPTH(FWD_DEPTH), .EXC_VECTOR(VEC)) dut (
        .clk(clk), .rst(rst), .hw_int_i(hw_int), .mem_valid_i(mem_valid),
        .mem_pc_i(mem_pc), .mem_bd_i(mem_bd), .mem_exc_i(mem_exc),
        .cp0_status_i(cp0_status), .cp0_cause_i(cp0_cause), .cp0_epc_i(cp0_epc),
        .fwd_wr_i(fwd_wr), .fwd_addr_i(fwd_addr), .fwd_data_i(fwd_data),
        .kill_o(kill), .flush_o(flush), .redirect_valid_o(rv), .redirect_pc_o(rpc),
        .redirect_ready_i(rdy), .commit_o(commit), .commit_code_o(ccode),
        .commit_epc_o(cepc), .commit_bd_o(bd), .eret_o(eret), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Effective CP0 register: youngest matching pending write, else architectural
    function automatic logic [31:0] eff_reg(input int addr, input logic [31:0] arch);
        for (int i = 0; i < int'(FWD_DEPTH); i++)
            if (fwd_wr[i] && fwd_addr[i] == 5'(addr)) return fwd_data[i];
        return arch;
    endfunction

    // Reference: which event the current MEM instruction raises
    task automatic model(output bit ev, output bit er, output logic [4:0] code,
                         output logic [31:0] tgt);
        logic [31:0] st, ca, cf, ep;
        logic [6:0]  fl;
        int          codes [7] = '{4, 10, 8, 9, 12, 5, 4};
        bit          pend;
        st = eff_reg(12, cp0_status);
        cf = eff_reg(13, cp0_cause);
        ep = eff_reg(14, cp0_epc);
        ca = cp0_cause;
        ca[9:8] = cf[9:8];
        for (int i = 0; i < int'(NUM_HWINT); i++) ca[10 + i] = hw_int[i];
        pend = ((ca[15:8] & st[15:8]) != 0) && (st[1] == 1'b0) && (st[0] == 1'b1);
        fl = {mem_exc.adel_if, mem_exc.ri, mem_exc.sys, mem_exc.bp,
              mem_exc.ov, mem_exc.ades, mem_exc.adel_dat};
        ev = 1'b0; er = 1'b0; code = 5'd0; tgt = VEC;
        if (pend) ev = 1'b1;
        else begin
            for (int i = 0; i < 7; i++)
                if (!ev && fl[6 - i]) begin ev = 1'b1; code = 5'(codes[i]); end
            if (!ev && mem_exc.eret) begin ev = 1'b1; er = 1'b1; tgt = ep; end
        end
    endtask

    task automatic clear_inputs();
        hw_int = '0; mem_valid = 1'b0; mem_pc = '0; mem_bd = 1'b0; mem_exc = '0;
        cp0_status = '0; cp0_cause = '0; cp0_epc = '0;
        fwd_wr = '0; fwd_addr = '0; fwd_data = '0; rdy = 1'b0;
    endtask

    // Idle long enough for any interrupt synchronizer to catch up
    task automatic settle();
        mem_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Full transaction for the instruction currently presented with mem_valid=1
    task automatic do_txn(input int waitc);
        bit ev, er;
        logic [4:0]  code;
        logic [31:0] tgt, xepc;
        model(ev, er, code, tgt);
        xepc = mem_bd ? mem_pc - 32'd4 : mem_pc;
        #1 chk("kill_resolve", kill, 32'(ev));
        @(posedge clk); #1;
        if (!ev) begin
            chk("busy_noevent", busy, 0);
            mem_valid = 1'b0;
            return;
        end
        chk("flush_pulse", flush, 1);
        chk("commit_pulse", commit, 32'(!er));
        chk("eret_pulse", eret, 32'(er));
        chk("busy_flush", busy, 1);
        chk("rv_flush", rv, 0);
        if (!er) begin
            chk("commit_code", ccode, code);
            chk("commit_epc", cepc, xepc);
            chk("commit_bd", bd, 32'(mem_bd));
        end
        mem_exc = '0; mem_exc.ov = 1'b1; mem_valid = 1'b1;
        #1 chk("kill_ignored_flush", kill, 0);
        @(posedge clk); #1;
        chk("flush_once", flush, 0);
        chk("commit_once", commit, 0);
        chk("eret_once", eret, 0);
        chk("rv_redirect", rv, 1);
        chk("rpc_redirect", rpc, tgt);
        for (int c = 0; c < waitc; c++) begin
            #1 chk("kill_ignored_wait", kill, 0);
            @(posedge clk); #1;
            chk("rv_hold", rv, 1);
            chk("rpc_hold", rpc, tgt);
            chk("busy_hold", busy, 1);
        end
        mem_valid = 1'b0; rdy = 1'b1;
        @(posedge clk); #1;
        chk("rv_done", rv, 0);
        chk("busy_done", busy, 0);
        rdy = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  v;
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rv", rv, 0);
        chk("rst_rpc", rpc, 0);
        chk("rst_commit", commit, 0);
        chk("rst_flush", flush, 0);
        rst = 1'b0;

        // Overflow, not in delay slot, long fetch stall
        clear_inputs();
        mem_exc.ov = 1'b1; mem_pc = 32'h80001000;
        settle(); mem_valid = 1'b1; do_txn(5);

        // Syscall in a delay slot
        clear_inputs();
        mem_exc.sys = 1'b1; mem_pc = 32'h80002004; mem_bd = 1'b1;
        settle(); mem_valid = 1'b1; do_txn(1);

        // ERET with EPC forwarded from youngest write
        clear_inputs();
        mem_exc.eret = 1'b1; cp0_epc = 32'h1000;
        fwd_wr[0] = 1'b1; fwd_addr[0] = 5'd14; fwd_data[0] = 32'h2000;
        settle(); mem_valid = 1'b1; do_txn(0);

        // Interrupt beats reserved instruction
        clear_inputs();
        cp0_status = 32'h0000FF01; hw_int[0] = 1'b1; mem_exc.ri = 1'b1;
        mem_pc = 32'h80003000;
        settle(); mem_valid = 1'b1; do_txn(2);

        // Interrupt latency from pin to Cause.IP
        clear_inputs();
        cp0_status = 32'h0000FF01; mem_pc = 32'h80004000;
        settle();
        hw_int[0] = 1'b1; mem_valid = 1'b1;
`ifdef EXC_INT_SYNC_EN
        #1 chk("int_sync_lat0", kill, 0);
        @(posedge clk); #1;
        chk("int_sync_lat1", kill, 0);
        @(posedge clk); #1;
        do_txn(0);
`else
        do_txn(0);
`endif

        // Reset while waiting in REDIRECT abandons the redirect
        clear_inputs();
        mem_exc.ov = 1'b1; mem_pc = 32'h80005000;
        settle(); mem_valid = 1'b1;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_rv", rv, 1);
        rst = 1'b1;
        #1;
        chk("midrst_rv", rv, 0);
        chk("midrst_rpc", rpc, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_code", ccode, 0);
        chk("midrst_epc", cepc, 0);
        chk("midrst_kill", kill, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("postrst_busy", busy, 0);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            clear_inputs();
            cp0_status = $urandom;
            if ($urandom_range(1, 0) == 1) cp0_status[1:0] = 2'b01;
            cp0_cause = $urandom;
            cp0_epc   = $urandom;
            for (int i = 0; i < int'(FWD_DEPTH); i++) begin
                fwd_wr[i] = 1'($urandom_range(1, 0));
                case ($urandom_range(3, 0))
                    0: fwd_addr[i] = 5'd12;
                    1: fwd_addr[i] = 5'd13;
                    2: fwd_addr[i] = 5'd14;
                    default: fwd_addr[i] = 5'($urandom);
                endcase
                fwd_data[i] = $urandom;
            end
            hw_int = ($urandom_range(1, 0) == 1) ? NUM_HWINT'($urandom) : '0;
            r = $urandom;
            mem_pc = r & 32'hFFFF_FFFC;
            mem_bd = 1'($urandom_range(1, 0));
            for (int b = 0; b < 8; b++) v[b] = ($urandom_range(4, 0) == 0);
            mem_exc = exc_vec_t'(v);
            settle(); mem_valid = 1'b1;
            do_txn(int'($urandom_range(3, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
